truth_sweep_ctrl: RTL and testbench

TRUTH_SWEEP_CTRL -- requirements
Module: truth_sweep_ctrl

---
 rtl/truth_sweep_ctrl_pkg.sv | 19 +
 rtl/truth_sweep_ctrl.sv | 100 ++++++++++
 tb/tb_truth_sweep_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/truth_sweep_ctrl_pkg.sv
// Shared constants for the truth-table sweep controller: FSM encoding,
// the vector application order and the default settle length.
package truth_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Gray-ordered walk over {A,B,C}: one input toggles per step.
  localparam logic [7:0][2:0] SEQ = {3'b111, 3'b101, 3'b100, 3'b110,
                                     3'b010, 3'b011, 3'b001, 3'b000};

  localparam int         SETTLE_DEF = 1;
  localparam logic [3:0] ERR_MAX    = 4'd8;

endpackage

// File: rtl/truth_sweep_ctrl.sv
// Sweeps all eight {A,B,C} vectors into a 3-input function block, captures
// its Y output per vector and counts mismatches against an expected table.
module truth_sweep_ctrl
  import truth_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_tbl,
  input  logic       y_in,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] cap_tbl,
  output logic [3:0] err_cnt
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] step;
  logic [3:0] settle_cnt;
  logic [7:0] exp_q;
  logic       mismatch;

  assign mismatch = (y_in != exp_q[abc]);

  // Expected table is pure data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      exp_q <= exp_tbl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      abc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      cap_tbl    <= '0;
      err_cnt    <= '0;
      step       <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          abc <= '0;
          if (start) begin
            cap_tbl    <= '0;
            err_cnt    <= '0;
            pass       <= 1'b0;
            step       <= '0;
            abc        <= SEQ[0];
            settle_cnt <= SETTLE_LAST;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          cap_tbl[abc] <= y_in;
          if (mismatch && err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + 4'd1;
          end
          if (step == 3'd7) begin
            abc   <= '0;
            state <= ST_DONE;
          end else begin
            step       <= step + 3'd1;
            abc        <= SEQ[step + 3'd1];
            settle_cnt <= SETTLE_LAST;
            state      <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // err_cnt already includes the final sample taken on the way in.
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == '0);
          abc   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed bench for truth_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// driven against an ideal or stuck-at function block model.
module tb_truth_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       start_x;
  logic [7:0] exp_x;
  logic       stuck;

  logic       start1, start3, y1, y3;
  logic [2:0] abc1, abc3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [7:0] cap1, cap3;
  logic [3:0] err1, err3;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq_t [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5, 3'd7};

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  assign start1 = !sel && start_x;
  assign start3 = sel && start_x;
  assign y1     = stuck ? 1'b0 : maj(abc1);
  assign y3     = stuck ? 1'b0 : maj(abc3);

  truth_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .exp_tbl(exp_x), .y_in(y1),
    .abc(abc1), .busy(busy1), .done(done1), .pass(pass1), .cap_tbl(cap1), .err_cnt(err1)
  );

  truth_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .exp_tbl(exp_x), .y_in(y3),
    .abc(abc3), .busy(busy3), .done(done3), .pass(pass3), .cap_tbl(cap3), .err_cnt(err3)
  );

  wire [2:0] abc_s  = sel ? abc3  : abc1;
  wire       busy_s = sel ? busy3 : busy1;
  wire       done_s = sel ? done3 : done1;
  wire       pass_s = sel ? pass3 : pass1;
  wire [7:0] cap_s  = sel ? cap3  : cap1;
  wire [3:0] err_s  = sel ? err3  : err1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Starts a sweep on the selected instance and checks the abc trace, busy,
  // done timing (8*(s+1)+1 cycles) and the single-cycle done pulse.
  task automatic run_sweep(input int s, input logic [7:0] exp_v, input bit repulse);
    int last;
    last    = 8 * (s + 1);
    exp_x   = exp_v;
    start_x = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      if (repulse) start_x = (k == 4);
      check("abc_trace", abc_s, (k < last) ? seq_t[k / (s + 1)] : 3'd0);
      check("busy_run", busy_s, 1'b1);
      check("done_early", done_s, 1'b0);
    end
    start_x = 1'b0;
    @(negedge clk);
    check("done_latency", done_s, 1'b1);
    check("busy_end", busy_s, 1'b0);
    check("abc_idle", abc_s, 3'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("done_single", done_s, 1'b0);
    end
  endtask

  task automatic check_results(input string tag, input logic [7:0] cap,
                               input logic [3:0] err, input logic ps);
    check({tag, "_cap"}, cap_s, cap);
    check({tag, "_err"}, err_s, err);
    check({tag, "_pass"}, pass_s, ps);
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    start_x = 1'b0;
    exp_x   = 8'h00;
    stuck   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_abc", {abc3, abc1}, 6'd0);
    check("rst_flags", {busy3, done3, pass3, busy1, done1, pass1}, 6'd0);
    check("rst_cap", {cap3, cap1}, 16'd0);
    check("rst_err", {err3, err1}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal majority block against its own truth table.
    run_sweep(1, 8'hE8, 1'b0);
    check_results("maj", 8'hE8, 4'd0, 1'b1);
    repeat (3) @(negedge clk);
    check_results("maj_hold", 8'hE8, 4'd0, 1'b1);

    // Y stuck low: the four ones of the majority table mismatch.
    stuck = 1'b1;
    run_sweep(1, 8'hE8, 1'b0);
    check_results("stuck0", 8'h00, 4'd4, 1'b0);
    stuck = 1'b0;

    // Complemented expectation: every vector mismatches, count tops out at 8.
    run_sweep(1, 8'h17, 1'b0);
    check_results("all_bad", 8'hE8, 4'd8, 1'b0);

    // A second start while busy must not restart or add a done pulse.
    run_sweep(1, 8'hE8, 1'b1);
    check_results("repulse", 8'hE8, 4'd0, 1'b1);

    // Asynchronous reset after the 4th vector has been sampled.
    stuck   = 1'b1;
    exp_x   = 8'hE8;
    start_x = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_abc", abc1, 3'd6);
    check("mid_err", err1, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_abc", abc1, 3'd0);
    check("async_flags", {busy1, done1, pass1}, 3'd0);
    check("async_cap", cap1, 8'h00);
    check("async_err", err1, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy1, abc1}, 4'd0);
    run_sweep(1, 8'hE8, 1'b0);
    check_results("post_rst", 8'hE8, 4'd0, 1'b1);

    // Start held high restarts on the first IDLE cycle after DONE.
    exp_x   = 8'hE8;
    start_x = 1'b1;
    @(negedge clk);
    repeat (17) @(negedge clk);
    check("held_done", done1, 1'b1);
    @(negedge clk);
    start_x = 1'b0;
    check("held_restart_busy", busy1, 1'b1);
    check("held_restart_done", done1, 1'b0);
    repeat (17) @(negedge clk);
    check("held_second_done", done1, 1'b1);
    repeat (2) @(negedge clk);

    // Longer settle: each vector held four cycles, done after 33.
    sel = 1'b1;
    @(negedge clk);
    run_sweep(3, 8'hE8, 1'b0);
    check_results("settle3", 8'hE8, 4'd0, 1'b1);
    check("settle3_other_idle", {busy1, done1}, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
